// File: rtl/hi_sim_subcarrier_tx.sv
// Tag-side HF transmitter: fetches bytes from the ARM over SSP into a 4-deep FIFO
// and plays them out as 848/424/212 kHz OOK or BPSK subcarrier load modulation.
module hi_sim_subcarrier_tx (
  input  logic ck_1356meg,
  input  logic reset,
  input  logic tx_enable,
  input  logic xcorr_is_848,
  input  logic xcorr_quarter_freq,
  input  logic mod_bpsk,
  input  logic ssp_dout,
  output logic ssp_clk,
  output logic ssp_frame,
  output logic pwr_oe1,
  output logic pwr_lo,
  output logic pwr_hi,
  output logic pwr_oe2,
  output logic pwr_oe3,
  output logic pwr_oe4,
  output logic dbg
);

  typedef enum logic {F_IDLE, F_SHIFT} fetch_state_t;
  typedef enum logic {IDLE, RUN} mod_state_t;

  fetch_state_t f_state, f_next;
  mod_state_t   m_state, m_next;

  logic [5:0] fc;
  logic [7:0] rx_shift;
  logic [7:0] fifo_mem [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] count;
  logic       push, pop;

  logic [7:0] tx_shift;
  logic [6:0] bit_cnt;
  logic [2:0] bit_idx;
  logic [1:0] mode_sc;
  logic       mode_bpsk;
  logic       bit_wrap, sc, cur_bit;

  // Fetch engine: one 64-cycle SSP transaction per byte, FPGA drives clock and frame.
  always_comb begin
    f_next = f_state;
    case (f_state)
      F_IDLE:  if (tx_enable && count <= 3'd3) f_next = F_SHIFT;
      F_SHIFT: if (fc == 6'd63) f_next = F_IDLE;
      default: f_next = F_IDLE;
    endcase
  end

  assign push      = (f_state == F_SHIFT) && (fc == 6'd63);
  assign ssp_clk   = (f_state == F_SHIFT) && !fc[2];
  assign ssp_frame = (f_state == F_SHIFT) && (fc[5:3] == 3'd0);

  always_ff @(posedge ck_1356meg or posedge reset) begin
    if (reset) begin
      f_state  <= F_IDLE;
      fc       <= 6'd0;
      rx_shift <= 8'd0;
    end else begin
      f_state <= f_next;
      fc      <= (f_state == F_SHIFT) ? fc + 6'd1 : 6'd0;
      if (f_state == F_SHIFT && fc[2:0] == 3'd4)
        rx_shift <= {rx_shift[6:0], ssp_dout};
    end
  end

  // FIFO: push and pop are single-cycle strobes; push never occurs when full and
  // pop never occurs when empty, so both may coincide without losing order.
  always_ff @(posedge ck_1356meg) begin
    if (push) fifo_mem[wr_ptr] <= rx_shift;
  end

  always_ff @(posedge ck_1356meg or posedge reset) begin
    if (reset) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  // Modulator FSM.
  assign bit_wrap = (bit_cnt == 7'd127);

  always_comb begin
    m_next = m_state;
    pop    = 1'b0;
    case (m_state)
      IDLE: if (count >= 3'd2) begin
        m_next = RUN;
        pop    = 1'b1;
      end
      RUN: if (bit_wrap && bit_idx == 3'd0) begin
        if (count != 3'd0) pop = 1'b1;
        else               m_next = IDLE;
      end
      default: m_next = IDLE;
    endcase
  end

  // Subcarrier is phase-locked to the bit boundary: high for the first half-period.
  always_comb begin
    case (mode_sc)
      2'd0:    sc = ~bit_cnt[3];
      2'd2:    sc = ~bit_cnt[5];
      default: sc = ~bit_cnt[4];
    endcase
  end

  assign cur_bit = tx_shift[bit_idx];

  always_ff @(posedge ck_1356meg or posedge reset) begin
    if (reset) begin
      m_state   <= IDLE;
      tx_shift  <= 8'd0;
      bit_cnt   <= 7'd0;
      bit_idx   <= 3'd0;
      mode_sc   <= 2'd0;
      mode_bpsk <= 1'b0;
      pwr_oe1   <= 1'b0;
    end else begin
      m_state <= m_next;
      pwr_oe1 <= (m_state == RUN) && (mode_bpsk ? (sc ^ cur_bit) : (sc & cur_bit));
      if (m_state == IDLE) begin
        if (pop) begin
          tx_shift  <= fifo_mem[rd_ptr];
          bit_cnt   <= 7'd0;
          bit_idx   <= 3'd7;
          mode_sc   <= xcorr_is_848 ? (xcorr_quarter_freq ? 2'd2 : 2'd0) : 2'd1;
          mode_bpsk <= mod_bpsk;
        end
      end else begin
        bit_cnt <= bit_cnt + 7'd1;
        if (bit_wrap) begin
          if (bit_idx != 3'd0) begin
            bit_idx <= bit_idx - 3'd1;
          end else if (pop) begin
            tx_shift <= fifo_mem[rd_ptr];
            bit_idx  <= 3'd7;
          end
        end
      end
    end
  end

  assign dbg     = (m_state == RUN);
  assign pwr_lo  = 1'b0;
  assign pwr_hi  = 1'b0;
  assign pwr_oe2 = 1'b0;
  assign pwr_oe3 = 1'b0;
  assign pwr_oe4 = 1'b0;

endmodule

// File: doc/hi_sim_subcarrier_tx.md
# hi_sim_subcarrier_tx

Tag-side transmitter for the 13.56 MHz HF path. It fetches modulation bytes from the ARM over the SSP link, with the FPGA as clock/frame master, and buffers them in a 4-byte FIFO. It plays them out bit-serially, at 128 carrier cycles per bit, as subcarrier load modulation on `pwr_oe1`. This is the counterpart of the reader-side I/Q correlating receiver: it generates the 848/424/212 kHz subcarrier, in OOK or BPSK, that the receiver correlates against.

## Interface
Parameters: none. Subcarrier and modulation modes are selected by ports.

- `ck_1356meg` in 1: 13.56 MHz carrier clock; the only clock. All logic is on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `tx_enable` in 1: ARM permission to fetch bytes, treated as quasi-static.
- `xcorr_is_848` in 1: subcarrier select, together with `xcorr_quarter_freq`.
  - `1/0`: 848 kHz.
  - `1/1`: 212 kHz.
  - `0/x`: 424 kHz.
- `xcorr_quarter_freq` in 1: see `xcorr_is_848`.
- `mod_bpsk` in 1: 0 = OOK, 1 = BPSK.
- `ssp_dout` in 1: serial data from the ARM, MSB first.
- `ssp_clk` out 1: SSP bit clock generated by this block.
- `ssp_frame` out 1: byte frame marker.
- `pwr_oe1` out 1: load-modulation drive, registered.
- `pwr_lo`, `pwr_hi`, `pwr_oe2`, `pwr_oe3`, `pwr_oe4` out 1 each: tied to 0.
- `dbg` out 1: 1 while the modulator FSM is in RUN.

## Operation

**Fetch engine** (states F_IDLE, F_SHIFT)
- F_IDLE → F_SHIFT when all of these hold: `tx_enable`=1, FIFO count ≤ 3, no fetch in flight.
  - Because only one fetch is in flight at a time, the count never exceeds 4.
- In F_SHIFT, a 6-bit counter `fc` runs 0..63. Bit index = `fc[5:3]`; phase = `fc[2:0]`.
  - `ssp_clk` = 1 for phase 0..3, 0 for phase 4..7.
  - `ssp_frame` = 1 for `fc` 0..7 only.
  - `ssp_dout` is sampled at phase 4, as `ssp_clk` falls, into a shift register, MSB first.
- At `fc`=63: push the byte into the FIFO and return to F_IDLE.
  - The next fetch may start on the following cycle.
- Dropping `tx_enable` mid-fetch does not abort it: the current byte completes and is pushed.
- In F_IDLE, `ssp_clk` and `ssp_frame` are 0.

**FIFO**
- 4 × 8 bits; 3-bit count 0..4.
- Push and pop in the same cycle: count unchanged, data order preserved.

**Modulator FSM** (states IDLE, RUN)
- IDLE → RUN when count ≥ 2. On transition:
  - pop a byte into `tx_shift`;
  - set `bit_cnt` (7 bits) = 0 and `bit_idx` = 7;
  - latch the mode inputs into `mode_sc` / `mode_bpsk`. They are held for the whole RUN.
- RUN: `bit_cnt` increments every cycle and wraps 127 → 0.
  - At wrap with `bit_idx` > 0: decrement `bit_idx`.
  - At wrap with `bit_idx` = 0 and FIFO non-empty: pop the next byte, `bit_idx` = 7, no gap.
  - At wrap with `bit_idx` = 0 and FIFO empty: go to IDLE.
- Subcarrier `sc` is phase-locked to bit boundaries: `sc` = ~`bit_cnt[k]`.
  - k = 3 for 848 kHz (period 16).
  - k = 4 for 424 kHz (period 32).
  - k = 5 for 212 kHz (period 64).
- Current bit b = `tx_shift[bit_idx]`.
- Next `pwr_oe1`:
  - OOK: `sc & b`.
  - BPSK: `sc ^ b`.
  - IDLE: 0.

## Timing
- All outputs are 0 in reset and immediately on `reset` assertion. After reset:
  - FIFO is empty;
  - both FSMs are idle;
  - all counters are 0.
- Fetch latency: 64 cycles per byte; FIFO count updates the cycle after `fc`=63.
- Modulator start:
  - the RUN transition occurs on the edge after count reaches 2;
  - the first `pwr_oe1` value (bit 7, `bit_cnt`=0) is visible one cycle after the transition.
- Bit period: exactly 128 cycles. Byte: 1024 cycles.
  - Consecutive bytes are seamless while the FIFO is non-empty.
- Fetch is 16× faster than playout. With `tx_enable`=1 the FIFO saturates at 4 and the fetch idles. Underrun happens only after `tx_enable` drops.
- Last output: `pwr_oe1` returns to 0 one cycle after the final bit's `bit_cnt`=127.
- Reset asserted mid-operation: everything clears asynchronously. An in-flight byte is discarded.

## Test plan
- **Reset during fetch:** assert `reset` at `fc`=20.
  - `ssp_clk`, `ssp_frame`, `pwr_oe1`, `dbg` all = 0 immediately.
  - After release, the first frame starts at `fc`=0.
- **Single fetch:** `tx_enable`=1, ARM shifts 0xA5.
  - `ssp_frame` is high for 8 cycles.
  - 8 `ssp_clk` pulses of 4 high / 4 low.
  - FIFO holds 0xA5 after 64 cycles.
- **OOK 848:** bytes 0x80, 0x00, then `tx_enable`=0.
  - `pwr_oe1` toggles 8 high / 8 low for 128 cycles, then stays 0 for 1920 cycles.
  - `dbg` falls after 2048 cycles.
- **BPSK 424:** byte 0x55 with pad bytes.
  - `pwr_oe1` has a period-32 square wave.
  - Phase inverts at every 128-cycle boundary within the byte: bit 7 = 0 gives normal phase, bit 6 = 1 gives inverted.
- **FIFO full:** `tx_enable`=1 held, with the modulator in IDLE.
  - Under the stated fetch rule, 2 bytes fetched switch the modulator to RUN, which consumes only one byte per 1024 cycles.
  - Count saturates at 4; `ssp_clk` then stays 0 until a pop.
  - Exactly one new fetch follows each pop.
- **Underrun and mode latch:** change `xcorr_quarter_freq` mid-RUN and drop `tx_enable` mid-fetch.
  - Subcarrier frequency stays unchanged until the next IDLE→RUN.
  - The in-flight byte completes and is played.
  - The FSM returns to IDLE with `pwr_oe1`=0.
